mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM plus ALU decoder for the multicycle MIPS datapath; sits directly upstream of the ALU.
- Drives ALUControl (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR) and the SrcA/SrcB select lines.
- Also drives the memory, IR, register-file and PC enables.
- Sequences lw, sw, R-type, beq, addi and j, with a MemReady wait handshake and a bus timeout.

Parameters:
- TIMEOUT, 16, max consecutive cycles waiting on MemReady before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- Op  in  6  instruction[31:26] from IR
- Funct  in  6  instruction[5:0] from IR
- Zero  in  1  ALU Zero flag
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select (0 = rt, 1 = rd)
- MemtoReg  out  1  write-data select (0 = ALUOut, 1 = Data)
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  SrcA select (0 = PC, 1 = A)
- ALUSrcB  out  2  SrcB select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2)
- ALUControl  out  3  ALU operation
- PCSrc  out  2  next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target)
- PCEn  out  1  PC load, = PCWrite | (Branch & Zero)
- BusError  out  1  sticky flag: a MemReady timeout occurred
- State  out  4  current state encoding, for debug

Behaviour:
- State register only; all outputs are a Moore decode of state, except:
  - PCEn uses Zero in BRANCH.
  - ALUControl uses Funct in EXECUTE.
  - IRWrite/PCEn/MemWrite qualification in FETCH/MEMWRITE uses MemReady.
- Defaults in every state: all enables 0, selects 0, ALUControl = 010.
- Reset: reset_n low at a clock edge -> State = FETCH, wait counter = 0, BusError = 0.
  - While reset_n is low, MemWrite, IRWrite, RegWrite and PCEn are forced to 0 combinationally.
- States and transitions:
  - FETCH: ALUSrcB = 01, ALUControl = 010, IRWrite = PCWrite = MemReady. Holds until MemReady, then -> DECODE.
  - DECODE: ALUSrcB = 11, ALUControl = 010 (branch target). Op routes:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - any other Op -> FETCH (NOP)
  - MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010. Op 100011 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD: IorD = 1. Holds until MemReady, then -> MEMWB.
  - MEMWB: MemtoReg = 1, RegWrite = 1 -> FETCH.
  - MEMWRITE: IorD = 1, MemWrite = 1 held until MemReady, then -> FETCH.
  - EXECUTE: ALUSrcA = 1, ALUSrcB = 00. Funct map:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - 100111 -> 100
    - Valid Funct -> ALUWB. Invalid Funct -> ALUControl = 010 and -> FETCH, with no writeback.
  - ALUWB: RegDst = 1, RegWrite = 1 -> FETCH.
  - BRANCH: ALUSrcA = 1, ALUControl = 110, PCSrc = 01, PCEn = Zero -> FETCH.
  - ADDIEXEC: ALUSrcA = 1, ALUSrcB = 10, ALUControl = 010 -> ADDIWB.
  - ADDIWB: RegWrite = 1 (RegDst = 0, MemtoReg = 0) -> FETCH.
  - JUMP: PCSrc = 10, PCEn = 1 -> FETCH.
- Latencies in cycles, with MemReady always high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE while MemReady = 0.
  - Clears on any state change or when MemReady = 1.
- Timeout (TIMEOUT > 0), when the counter reaches TIMEOUT with MemReady still 0:
  - That cycle all enables stay 0.
  - Next state = FETCH; BusError is set sticky; the counter clears.
  - Effect: a lw/sw is aborted with no writeback, or the fetch is restarted.
- Simultaneous MemReady = 1 and timeout on the same cycle: MemReady wins, normal transition, no error.
- 4-bit counter saturates; TIMEOUT values above 15 are clamped to 15.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum, 4-bit: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEXEC = 9, ADDIWB = 10, JUMP = 11;
  - opcode constants;
  - funct constants;
  - the ALUControl encodings.
- One sub-module, alu_decoder: purely combinational Funct -> {ALUControl, FunctValid}.
  - Instantiated in the FSM; ALUControl is muxed by state.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with MemReady = 1 -> State = 0, PCEn = IRWrite = RegWrite = MemWrite = 0, BusError = 0. Release -> next edge State = 1.
- R-type: Op = 000000, Funct = 100111 (NOR) -> states 0,1,6,7,0. ALUControl = 100 in EXECUTE; RegDst = 1 and RegWrite = 1 in ALUWB. Repeat with Funct = 101010 -> ALUControl = 111.
- lw with MemReady low 3 cycles in MEMREAD -> State = 3 for 4 cycles with IorD = 1, then MEMWB with MemtoReg = 1, RegWrite = 1.
  - sw -> MemWrite = 1 held until MemReady, then FETCH.
- beq: Op = 000100, Zero = 1 -> PCEn = 1, PCSrc = 01, ALUControl = 110. Same with Zero = 0 -> PCEn = 0.
- Timeout: TIMEOUT = 4, MemReady stuck 0 in MEMREAD -> after 4 waiting cycles State = 0, BusError = 1, no RegWrite ever asserted.
  - MemReady = 1 exactly on the 4th waiting cycle -> MEMWB, BusError stays 0.
- Unknown encodings: Op = 111111 -> DECODE -> FETCH with no enables. Op = 000000, Funct = 000000 -> EXECUTE -> FETCH, RegWrite never asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and ALU encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational R-type funct to ALU operation decoder
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] Funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  // Map funct field to ALU operation; unknown functs fall back to ADD and flag invalid
  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (Funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_NOR:  alu_ctrl = ALU_NOR;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM with memory wait timeout
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       BusError,
  output logic [3:0] State
);

  // Counter is only 4 bits wide, so larger limits are clamped
  localparam logic [3:0] TMO_LIM = (TIMEOUT > 15) ? 4'd15 : 4'(TIMEOUT);
  localparam bit         TMO_EN  = (TIMEOUT > 0);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       bus_error;
  logic       waiting, timeout;
  logic       mem_write_raw, ir_write_raw, reg_write_raw, pc_write, branch;
  logic [2:0] dec_alu;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .Funct       (Funct),
    .alu_ctrl    (dec_alu),
    .funct_valid (funct_valid)
  );

  // A cycle counts as waiting only in the memory-access states with MemReady low;
  // timeout fires on the waiting cycle that brings the count to the limit
  assign waiting = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !MemReady;
  assign timeout = TMO_EN && waiting && (wait_cnt == (TMO_LIM - 4'd1));

  // State register, saturating wait counter and sticky bus-error flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH;
      wait_cnt  <= 4'd0;
      bus_error <= 1'b0;
    end else begin
      state <= state_next;
      if (waiting && !timeout)
        wait_cnt <= (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= 4'd0;
      if (timeout)
        bus_error <= 1'b1;
    end
  end

  // Next-state and Moore output decode; MemReady/Zero/Funct qualify a few outputs
  always_comb begin
    state_next    = state;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    PCSrc         = 2'b00;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB      = 2'b01;
        ir_write_raw = MemReady;
        pc_write     = MemReady;
        if (MemReady) state_next = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD = 1'b1;
        if (MemReady)     state_next = MEMWB;
        else if (timeout) state_next = FETCH;
      end
      MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      MEMWRITE: begin
        IorD          = 1'b1;
        mem_write_raw = !timeout;
        if (MemReady || timeout) state_next = FETCH;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_valid ? dec_alu : ALU_ADD;
        state_next = funct_valid ? ALUWB : FETCH;
      end
      ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        state_next = FETCH;
      end
      ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign MemWrite = mem_write_raw & reset_n;
  assign IRWrite  = ir_write_raw & reset_n;
  assign RegWrite = reg_write_raw & reset_n;
  assign PCEn     = (pc_write | (branch & Zero)) & reset_n;
  assign BusError = bus_error;
  assign State    = state;

endmodule
